// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for the datapath.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;
    // Widest busy vector that popcount accepts; narrower vectors are zero-extended.
    localparam int POP_MAX      = 256;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Pending-write scoreboard: busy bits, set/clear priority, occupancy count and issue gating.
// Optional feature: REGFILE_BYPASS_EN lets a same-cycle write-back mask the busy bit it clears.
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_src_a,
    input  logic [ADDR_W-1:0]   iss_src_b,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic                iss_long,
    output logic                iss_ready,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     pending_cnt
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] eb;

    always_comb begin
        eb = busy_q;
`ifdef REGFILE_BYPASS_EN
        if (wb_valid) eb[wb_addr] = 1'b0;
`endif
    end

    assign iss_ready = !eb[iss_src_a] && !eb[iss_src_b] && !eb[iss_dst];

    // Issue set is applied after the write-back clear so it wins on the same register.
    always_comb begin
        busy_next = busy_q;
        if (wb_valid) busy_next[wb_addr] = 1'b0;
        if (iss_valid && iss_ready && iss_long) busy_next[iss_dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) busy_q <= '0;
        else     busy_q <= busy_next;
    end

    assign busy        = busy_q;
    assign pending_cnt = (ADDR_W+1)'(popcount(POP_MAX'(busy_q)));

endmodule

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with two read ports, one write-back port and a busy scoreboard.
// Optional feature: REGFILE_BYPASS_EN forwards write-back data to both read ports in the same cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DATA_W_DEF,
    parameter int  NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    input  logic                ba_a,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_src_a,
    input  logic [ADDR_W-1:0]   iss_src_b,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic                iss_long,
    output logic                iss_ready,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     pending_cnt
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Base-address zeroing is applied last so it overrides a bypassed write to R0.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && wb_addr == rd_addr_a) rd_data_a = wb_data;
        if (wb_valid && wb_addr == rd_addr_b) rd_data_b = wb_data;
`endif
        if (ba_a && rd_addr_a == '0) rd_data_a = '0;
    end

    busy_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_busy_scoreboard (
        .clk         (clk),
        .clr         (clr),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .iss_valid   (iss_valid),
        .iss_src_a   (iss_src_a),
        .iss_src_b   (iss_src_b),
        .iss_dst     (iss_dst),
        .iss_long    (iss_long),
        .iss_ready   (iss_ready),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: behavioural model on the default 16x32 build plus a 32x64 instance.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  rd_addr_a, rd_addr_b, wb_addr, iss_src_a, iss_src_b, iss_dst;
    logic        ba_a, wb_valid, iss_valid, iss_long, iss_ready;
    logic [31:0] rd_data_a, rd_data_b, wb_data;
    logic [15:0] busy;
    logic [4:0]  pending_cnt;

    logic [4:0]  rd2_a, rd2_b, wb2_addr, iss2_src_a, iss2_src_b, iss2_dst;
    logic        ba2, wb2_valid, iss2_valid, iss2_long, iss2_ready;
    logic [63:0] rd2_data_a, rd2_data_b, wb2_data;
    logic [31:0] busy2;
    logic [5:0]  pending2;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    logic [31:0] m_regs [16];
    logic [15:0] m_busy;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .clr(clr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .ba_a(ba_a),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .iss_valid(iss_valid), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
        .iss_dst(iss_dst), .iss_long(iss_long), .iss_ready(iss_ready), .busy(busy),
        .pending_cnt(pending_cnt)
    );

    regfile_scoreboard #(.DATA_W(64), .NUM_REGS(32)) dut_wide (
        .clk(clk), .clr(clr), .rd_addr_a(rd2_a), .rd_addr_b(rd2_b), .ba_a(ba2),
        .rd_data_a(rd2_data_a), .rd_data_b(rd2_data_b), .wb_valid(wb2_valid), .wb_addr(wb2_addr),
        .wb_data(wb2_data), .iss_valid(iss2_valid), .iss_src_a(iss2_src_a), .iss_src_b(iss2_src_b),
        .iss_dst(iss2_dst), .iss_long(iss2_long), .iss_ready(iss2_ready), .busy(busy2),
        .pending_cnt(pending2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a register is a hazard unless a bypassed write-back is retiring it right now.
    function automatic bit m_hazard(input logic [3:0] r);
        return m_busy[r] && !(BYP && wb_valid && wb_addr == r);
    endfunction

    function automatic bit m_ready();
        return !m_hazard(iss_src_a) && !m_hazard(iss_src_b) && !m_hazard(iss_dst);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a, input bit port_a);
        if (port_a && ba_a && a == 4'd0) return 32'd0;
        if (BYP && wb_valid && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int r = 0; r < 16; r++) if (m_busy[r]) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < 16; r++) m_regs[r] = 32'd0;
            m_busy = 16'd0;
        end else begin
            bit fire;
            fire = iss_valid && m_ready();
            if (wb_valid) begin
                m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (fire && iss_long) m_busy[iss_dst] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_rd_a", 64'(rd_data_a), 64'(m_read(rd_addr_a, 1'b1)));
            chk("cmp_rd_b", 64'(rd_data_b), 64'(m_read(rd_addr_b, 1'b0)));
            chk("cmp_ready", 64'(iss_ready), 64'(m_ready()));
            chk("cmp_busy", 64'(busy), 64'(m_busy));
            chk("cmp_pending", 64'(pending_cnt), 64'(m_pending()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; ba_a = 1'b0; wb_valid = 1'b0; iss_valid = 1'b0; iss_long = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; wb_addr = '0; wb_data = '0;
        iss_src_a = '0; iss_src_b = '0; iss_dst = '0;
        ba2 = 1'b0; wb2_valid = 1'b0; iss2_valid = 1'b0; iss2_long = 1'b0;
        rd2_a = '0; rd2_b = '0; wb2_addr = '0; wb2_data = '0;
        iss2_src_a = '0; iss2_src_b = '0; iss2_dst = '0;

        step();
        clr = 1'b0;
        check_en = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pending", 64'(pending_cnt), 64'd0);
        chk("rst_ready", 64'(iss_ready), 64'd1);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            step();
            chk("rst_rd_a", 64'(rd_data_a), 64'd0);
            chk("rst_rd_b", 64'(rd_data_b), 64'd0);
        end

        wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF; rd_addr_a = 4'd5;
        step();
        wb_valid = 1'b0;
        #1 chk("wr_r5", 64'(rd_data_a), 64'hDEADBEEF);
        chk("wr_r5_busy", 64'(busy), 64'd0);

        wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 32'h1234;
        step();
        wb_valid = 1'b0; ba_a = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        #1 chk("ba_port_a", 64'(rd_data_a), 64'd0);
        chk("ba_port_b", 64'(rd_data_b), 64'h1234);
        step();
        ba_a = 1'b0;

        iss_valid = 1'b1; iss_long = 1'b1; iss_dst = 4'd3; iss_src_a = 4'd1; iss_src_b = 4'd2;
        #1 chk("long_ready", 64'(iss_ready), 64'd1);
        step();
        iss_valid = 1'b0; iss_long = 1'b0;
        #1 chk("long_busy", 64'(busy), 64'h0008);
        chk("long_pending", 64'(pending_cnt), 64'd1);
        iss_valid = 1'b1; iss_src_a = 4'd3; iss_src_b = 4'd1; iss_dst = 4'd4;
        #1 chk("haz_stall0", 64'(iss_ready), 64'd0);
        step();
        chk("haz_stall1", 64'(iss_ready), 64'd0);
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'h42; rd_addr_a = 4'd3; rd_addr_b = 4'd5;
        #1 chk("haz_wb_ready", 64'(iss_ready), BYP ? 64'd1 : 64'd0);
        chk("haz_wb_rd", 64'(rd_data_a), BYP ? 64'h42 : 64'd0);
        step();
        wb_valid = 1'b0;
        #1 chk("haz_after_ready", 64'(iss_ready), 64'd1);
        chk("haz_after_rd", 64'(rd_data_a), 64'h42);
        chk("haz_after_busy", 64'(busy), 64'd0);
        step();
        iss_valid = 1'b0;

        iss_valid = 1'b1; iss_long = 1'b1; iss_dst = 4'd3; iss_src_a = 4'd0; iss_src_b = 4'd0;
        step();
        #1 chk("relong_ready", 64'(iss_ready), 64'd0);
        step();
        iss_valid = 1'b0; iss_long = 1'b0;
        #1 chk("relong_pending", 64'(pending_cnt), 64'd1);
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'h99;
        step();
        wb_valid = 1'b0;

        iss_valid = 1'b1; iss_long = 1'b1; iss_dst = 4'd7;
        step();
        iss_valid = 1'b0;
        #1 chk("sim_pre_busy", 64'(busy), 64'h0080);
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h77; iss_valid = 1'b1;
        step();
        wb_valid = 1'b0; iss_valid = 1'b0; iss_long = 1'b0; rd_addr_b = 4'd7;
        #1 chk("sim_data", 64'(rd_data_b), 64'h77);
        chk("sim_busy", 64'(busy), BYP ? 64'h0080 : 64'd0);
        chk("sim_pending", 64'(pending_cnt), BYP ? 64'd1 : 64'd0);
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h78;
        step();
        wb_valid = 1'b0;
        #1 chk("sim_clean", 64'(pending_cnt), 64'd0);

        iss_valid = 1'b1; iss_long = 1'b1; iss_dst = 4'd2;
        step();
        iss_dst = 4'd9;
        step();
        iss_valid = 1'b0; iss_long = 1'b0;
        #1 chk("mid_pending", 64'(pending_cnt), 64'd2);
        chk("mid_busy", 64'(busy), 64'h0204);
        clr = 1'b1; wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 32'h55;
        step();
        clr = 1'b0; wb_valid = 1'b0; rd_addr_a = 4'd2; rd_addr_b = 4'd5;
        #1 chk("clr_r2", 64'(rd_data_a), 64'd0);
        chk("clr_r5", 64'(rd_data_b), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_pending", 64'(pending_cnt), 64'd0);

        for (int i = 0; i < 32; i++) begin
            iss2_valid = 1'b1; iss2_long = 1'b1;
            iss2_dst = 5'(i); iss2_src_a = 5'(i); iss2_src_b = 5'(i);
            #1 chk("wide_fill_ready", 64'(iss2_ready), 64'd1);
            step();
        end
        iss2_valid = 1'b0; iss2_long = 1'b0; iss2_src_a = 5'd0;
        #1 chk("wide_pending", 64'(pending2), 64'd32);
        chk("wide_busy", 64'(busy2), 64'hFFFF_FFFF);
        chk("wide_stall", 64'(iss2_ready), 64'd0);
        wb2_valid = 1'b1; wb2_addr = 5'd31; wb2_data = 64'hFFFF_FFFF_0000_0001;
        rd2_a = 5'd31; rd2_b = 5'd31;
        step();
        wb2_valid = 1'b0;
        #1 chk("wide_rd_a", rd2_data_a, 64'hFFFF_FFFF_0000_0001);
        chk("wide_rd_b", rd2_data_b, 64'hFFFF_FFFF_0000_0001);
        chk("wide_pending31", 64'(pending2), 64'd31);

        step();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
